// File: rtl/fifo_write_ingress.sv
// -----------------------------------------------------------------------------
// fifo_write_ingress
//
// Write-side ingress stage of the asynchronous FIFO, in the write clock domain.
// Producer words enter through a valid/ready handshake into a two-entry skid
// buffer: an output register that feeds write_data, plus one skid register.
// The buffer drives write_inc/write_data into the pointer and memory stages.
// Because in_ready is registered, producer backpressure never depends
// combinationally on write_full.
//
// The stage also reports write-side occupancy and an almost-full flag. Both
// are derived from the Gray write pointer and the synchronized Gray read
// pointer.
//
// Optional feature macro: FIFO_INGRESS_STATS_EN
//   When defined, stall_count counts the cycles in which a word is buffered
//   while write_full is high. The count saturates at 0xFFFF.
//   When undefined, stall_count is tied to zero.
//
// Ports
//   write_clk          in   write-domain clock
//   write_reset_n      in   synchronous, active-low reset
//   in_valid           in   producer data valid
//   in_data            in   producer data [DSIZE]
//   in_ready           out  ingress can accept (registered)
//   write_full         in   registered full flag from the pointer stage
//   write_pointer      in   current write pointer, Gray [SIZE+1]
//   read_pointer_grey  in   synchronized read pointer, Gray [SIZE+1]
//   almost_full_thresh in   almost-full threshold in entries [SIZE+1]
//   write_inc          out  push one word into the FIFO this cycle
//   write_data         out  word written when write_inc is high [DSIZE]
//   write_level        out  occupancy 0..2^SIZE (registered) [SIZE+1]
//   write_almost_full  out  write_level >= almost_full_thresh (registered)
//   stall_count        out  stall statistics [16]
// -----------------------------------------------------------------------------
module fifo_write_ingress #(
    parameter int SIZE  = 4,
    parameter int DSIZE = 8
) (
    input  logic             write_clk,
    input  logic             write_reset_n,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    input  logic             write_full,
    input  logic [SIZE:0]    write_pointer,
    input  logic [SIZE:0]    read_pointer_grey,
    input  logic [SIZE:0]    almost_full_thresh,
    output logic             write_inc,
    output logic [DSIZE-1:0] write_data,
    output logic [SIZE:0]    write_level,
    output logic             write_almost_full,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_r;
    logic [DSIZE-1:0] out_data_r;
    logic [DSIZE-1:0] skid_data_r;
    logic             in_ready_r;
    logic [SIZE:0]    level_r;
    logic             almost_full_r;

    logic             accept_s;
    logic             drain_s;
    logic [SIZE:0]    level_nxt_s;
    logic             almost_full_nxt_s;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [SIZE:0] gray_to_bin(input logic [SIZE:0] gray);
        logic [SIZE:0] bin;
        bin[SIZE] = gray[SIZE];
        for (int i = SIZE - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Handshake and drain qualifiers. Drain is allowed only when a word is held
    // and the pointer stage is not full.
    always_comb begin
        accept_s = in_valid & in_ready_r;
        drain_s  = (state_r != ST_EMPTY) & ~write_full;
    end

    assign write_inc  = drain_s;
    assign write_data = out_data_r;
    assign in_ready   = in_ready_r;

    // Skid-buffer state machine. in_ready is registered as "next state is not TWO".
    // In TWO the producer is already blocked, so no accept can occur there.
    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            state_r     <= ST_EMPTY;
            out_data_r  <= {DSIZE{1'b0}};
            skid_data_r <= {DSIZE{1'b0}};
            in_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        state_r    <= ST_ONE;
                        out_data_r <= in_data;
                    end else begin
                        state_r    <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        state_r    <= ST_ONE;
                        out_data_r <= in_data;
                        in_ready_r <= 1'b1;
                    end else if (accept_s) begin
                        state_r     <= ST_TWO;
                        skid_data_r <= in_data;
                        in_ready_r  <= 1'b0;
                    end else if (drain_s) begin
                        state_r    <= ST_EMPTY;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        state_r    <= ST_ONE;
                        out_data_r <= skid_data_r;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_TWO;
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_EMPTY;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy from the two pointers. The subtraction wraps modulo 2^(SIZE+1),
    // so the case where the write pointer has wrapped past the read pointer is
    // handled for free.
    always_comb begin
        level_nxt_s       = gray_to_bin(write_pointer) - gray_to_bin(read_pointer_grey);
        almost_full_nxt_s = (level_nxt_s >= almost_full_thresh);
    end

    // Register the level and almost-full outputs.
    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            level_r       <= {(SIZE+1){1'b0}};
            almost_full_r <= 1'b0;
        end else begin
            level_r       <= level_nxt_s;
            almost_full_r <= almost_full_nxt_s;
        end
    end

    assign write_level       = level_r;
    assign write_almost_full = almost_full_r;

`ifdef FIFO_INGRESS_STATS_EN
    logic [15:0] stall_r;

    // Count cycles in which a buffered word is blocked by write_full.
    // The counter saturates rather than wrapping.
    always_ff @(posedge write_clk) begin
        if (!write_reset_n) begin
            stall_r <= 16'd0;
        end else if ((state_r != ST_EMPTY) && write_full && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_count = stall_r;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_write_ingress.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_ingress
//
// Self-checking bench for fifo_write_ingress.
//
// The reference model treats the ingress as a bounded queue of at most two
// words:
//   - write_inc  = queue not empty and not full
//   - write_data = head of the queue
//   - in_ready   = queue did not hold two words after the previous edge
// The pointers are kept in binary and Gray-encoded when driven to the DUT.
// The expected level is the plain modular difference of the binary pointers.
// -----------------------------------------------------------------------------
module tb_fifo_write_ingress;

    localparam int SIZE  = 4;
    localparam int DSIZE = 8;
`ifdef FIFO_INGRESS_STATS_EN
    localparam int STALL_RUN = 70000;
`else
    localparam int STALL_RUN = 100;
`endif

    logic             write_clk = 1'b0;
    logic             write_reset_n;
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_ready;
    logic             write_full;
    logic [SIZE:0]    write_pointer;
    logic [SIZE:0]    read_pointer_grey;
    logic [SIZE:0]    almost_full_thresh;
    logic             write_inc;
    logic [DSIZE-1:0] write_data;
    logic [SIZE:0]    write_level;
    logic             write_almost_full;
    logic [15:0]      stall_count;

    always #5 write_clk = ~write_clk;

    fifo_write_ingress #(.SIZE(SIZE), .DSIZE(DSIZE)) dut (
        .write_clk          (write_clk),
        .write_reset_n      (write_reset_n),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .write_full         (write_full),
        .write_pointer      (write_pointer),
        .read_pointer_grey  (read_pointer_grey),
        .almost_full_thresh (almost_full_thresh),
        .write_inc          (write_inc),
        .write_data         (write_data),
        .write_level        (write_level),
        .write_almost_full  (write_almost_full),
        .stall_count        (stall_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state.
    logic [DSIZE-1:0] q[$];
    logic             m_ready;
    logic [SIZE:0]    m_level;
    logic             m_af;
    logic [15:0]      m_stall;
    logic [SIZE:0]    w_bin;
    logic [SIZE:0]    r_bin;
    logic [7:0]       seq;

    assign write_pointer     = w_bin ^ (w_bin >> 1);
    assign read_pointer_grey = r_bin ^ (r_bin >> 1);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        bit acc;
        bit drn;
        if (!write_reset_n) begin
            q.delete();
            m_ready = 1'b0;
            m_level = '0;
            m_af    = 1'b0;
            m_stall = 16'd0;
        end else begin
            acc = in_valid && m_ready;
            drn = (q.size() != 0) && !write_full;
`ifdef FIFO_INGRESS_STATS_EN
            if ((q.size() != 0) && write_full && (m_stall != 16'hFFFF)) m_stall++;
`endif
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            m_ready = (q.size() != 2);
            m_level = w_bin - r_bin;
            m_af    = (m_level >= almost_full_thresh);
        end
    endtask

    // Compare the DUT outputs with the model, then advance one clock.
    // Inputs are driven at the negedge; outputs are sampled 1 ns later.
    task automatic step(input bit chk);
        #1;
        if (chk) begin
            check_val("in_ready",    32'(in_ready),          32'(m_ready));
            check_val("write_inc",   32'(write_inc),         32'((q.size() != 0) && !write_full));
            check_val("write_level", 32'(write_level),       32'(m_level));
            check_val("almost_full", 32'(write_almost_full), 32'(m_af));
            check_val("stall_count", 32'(stall_count),       32'(m_stall));
            if (q.size() != 0) check_val("write_data", 32'(write_data), 32'(q[0]));
        end
        @(posedge write_clk);
        model_edge();
        @(negedge write_clk);
    endtask

    // Producer cycle: present seq. Advance seq only when the word was accepted.
    task automatic send_cycle(input bit valid);
        bit took;
        in_valid = valid;
        in_data  = seq;
        took     = valid && m_ready;
        step(1'b1);
        if (took) seq++;
    endtask

    initial begin
        write_reset_n      = 1'b0;
        in_valid           = 1'b1;
        in_data            = 8'h00;
        write_full         = 1'b0;
        w_bin              = '0;
        r_bin              = '0;
        almost_full_thresh = 5'd0;
        seq                = 8'h00;
        m_ready            = 1'b0;
        m_level            = '0;
        m_af               = 1'b0;
        m_stall            = 16'd0;

        // Reset with in_valid held high. The threshold is 0, so almost-full
        // must assert at the first edge after release.
        step(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1);
        write_reset_n = 1'b1;
        in_valid      = 1'b0;
        step(1'b1);
        check_val("rdy_after_rst", 32'(in_ready),          32'd1);
        check_val("af_thresh0",    32'(write_almost_full), 32'd1);

        // Streaming: 20 back-to-back words 0x00..0x13.
        almost_full_thresh = 5'd16;
        seq = 8'h00;
        for (int i = 0; i < 20; i++) send_cycle(1'b1);
        check_val("stream_seq", 32'(seq), 32'd20);
        for (int i = 0; i < 3; i++) send_cycle(1'b0);

        // Backpressure mid-stream, then release.
        seq = 8'h40;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) write_full = 1'b1;
            if (i == 9) write_full = 1'b0;
            send_cycle(1'b1);
        end
        for (int i = 0; i < 4; i++) send_cycle(1'b0);

        // Level and almost-full cases.
        almost_full_thresh = 5'd12;
        w_bin = 5'd13; r_bin = 5'd1;
        step(1'b1);
        step(1'b1);
        check_val("lvl_13_1", 32'(write_level),       32'd12);
        check_val("af_13_1",  32'(write_almost_full), 32'd1);
        w_bin = 5'd2; r_bin = 5'd30;
        step(1'b1);
        step(1'b1);
        check_val("lvl_wrap", 32'(write_level),       32'd4);
        check_val("af_wrap",  32'(write_almost_full), 32'd0);
        w_bin = 5'd16; r_bin = 5'd0;
        step(1'b1);
        step(1'b1);
        check_val("lvl_full", 32'(write_level), 32'd16);

        // Reset while two words are buffered.
        write_full = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5; step(1'b1);
        in_data = 8'h5A; step(1'b1);
        in_valid = 1'b0; step(1'b1);
        check_val("two_held_rdy", 32'(in_ready), 32'd0);
        write_reset_n = 1'b0; step(1'b1);
        write_reset_n = 1'b1; write_full = 1'b0;
        check_val("rst_mid_inc", 32'(write_inc), 32'd0);
        step(1'b1);
        in_valid = 1'b1; in_data = 8'h3C; step(1'b1);
        in_valid = 1'b0; step(1'b1);
        check_val("post_rst_data", 32'(write_data), 32'h3C);

        // Randomized traffic with pointer random walk.
        for (int i = 0; i < 400; i++) begin
            write_full = ($urandom_range(0, 3) == 0);
            if (($urandom_range(0, 1) == 1) && (5'(w_bin - r_bin) < 5'd16)) w_bin = w_bin + 5'd1;
            if (($urandom_range(0, 1) == 1) && (w_bin != r_bin)) r_bin = r_bin + 5'd1;
            if ($urandom_range(0, 31) == 0) almost_full_thresh = 5'($urandom_range(0, 16));
            send_cycle($urandom_range(0, 2) != 0);
        end

        // Stall statistics: one buffered word blocked by write_full.
        write_full = 1'b0;
        in_valid = 1'b0;
        write_reset_n = 1'b0; step(1'b1);
        write_reset_n = 1'b1; step(1'b1);
        write_full = 1'b1;
        send_cycle(1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1);
`ifdef FIFO_INGRESS_STATS_EN
        check_val("stall_10", 32'(stall_count), 32'd10);
`else
        check_val("stall_off", 32'(stall_count), 32'd0);
`endif
        for (int i = 0; i < STALL_RUN; i++) step(1'b0);
        step(1'b1);
`ifdef FIFO_INGRESS_STATS_EN
        check_val("stall_sat", 32'(stall_count), 32'hFFFF);
`else
        check_val("stall_off_long", 32'(stall_count), 32'd0);
`endif
        write_full = 1'b0;
        step(1'b1);
        step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fifo_write_ingress.md
# fifo_write_ingress

Write-side ingress stage of the asynchronous FIFO, in the write clock domain, directly upstream of the write pointer stage. Accepts a valid/ready stream from the producer through a two-entry skid buffer and drives `write_inc` and `write_data` into the pointer and memory stages, so producer backpressure never depends combinationally on `write_full`. Also reports write-side occupancy and a programmable almost-full flag, derived from the write pointer and the synchronized read pointer (both Gray).

## Interface
- `SIZE`, 4, address width; FIFO depth 2^SIZE; pointers are SIZE+1 bits
- `DSIZE`, 8, data width

- `write_clk`  in  1  write-domain clock
- `write_reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  producer data valid
- `in_data`  in  DSIZE  producer data
- `in_ready`  out  1  ingress can accept; registered
- `write_full`  in  1  registered full flag from the pointer stage
- `write_pointer`  in  SIZE+1  current write pointer (Gray)
- `read_pointer_grey`  in  SIZE+1  synchronized read pointer (Gray)
- `almost_full_thresh`  in  SIZE+1  almost-full threshold (entries)
- `write_inc`  out  1  push one word into FIFO this cycle
- `write_data`  out  DSIZE  word written when `write_inc`=1
- `write_level`  out  SIZE+1  occupancy, 0..2^SIZE; registered
- `write_almost_full`  out  1  `write_level >= almost_full_thresh`; registered
- `stall_count`  out  16  stall statistics (see Configuration)

## Operation
- accept = `in_valid & in_ready`; drain = `write_inc`.
- Storage: output register (feeds `write_data`) plus one skid register. State machine, reset to EMPTY:
  - EMPTY: accept -> ONE (load output reg).
  - ONE: accept&drain -> ONE (output reg <= `in_data`); accept&~drain -> TWO (skid <= `in_data`); ~accept&drain -> EMPTY; otherwise hold.
  - TWO: drain -> ONE (output reg <= skid); otherwise hold. Accept impossible.
- `write_inc` = (state != EMPTY) & ~`write_full`, combinational. `write_data` = output register.
- `in_ready` register: next = (next state != TWO). While reset is asserted, `in_ready` is 0 and no accept occurs.
- Strict FIFO order, no drops, no duplicates.
- Level: convert both Gray pointers to binary (XOR prefix from MSB). next level = (wbin - rbin) mod 2^(SIZE+1). Values above 2^SIZE cannot occur with legal inputs and are not checked.
- `write_almost_full` next = (next level >= `almost_full_thresh`), unsigned. Threshold 0 asserts it from the first edge after reset.
- Reset values: state EMPTY, output/skid regs 0, `in_ready` 0, `write_level` 0, `write_almost_full` 0, `stall_count` 0. `write_inc` is 0 during reset because the state is EMPTY.
- Reset mid-operation: buffered words are discarded at the resetting edge. The pointer stage resets in the same domain.

## Timing
- Accept at edge N -> word on `write_data` and `write_inc`=1 (if not full) from cycle N+1. Latency is 1 cycle when the buffer is empty.
- Sustained throughput of 1 word/cycle while `write_full`=0.
- `write_full` rising: at most one further accept (into skid), then `in_ready`=0 the cycle after TWO is entered.
- `write_full` falling: drain the same cycle. `in_ready` returns 1 the cycle after leaving TWO.
- `write_level` and `write_almost_full` lag pointer inputs by 1 cycle. Occupancy is pessimistic by the read-pointer synchronizer delay.

## Configuration
- `FIFO_INGRESS_STATS_EN` defined: `stall_count` increments on every cycle with state != EMPTY and `write_full`=1. It saturates at 0xFFFF, clears on reset, and updates 1 cycle after the stall cycle.
- Not defined: no counter logic; `stall_count` tied to 0.

## Test plan
- Reset: `write_reset_n`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `write_inc`=0, `write_level`=0 throughout. `in_ready`=1 one cycle after release.
- Streaming: `write_full`=0, 20 back-to-back words 0x00..0x13 -> `write_inc` high 20 consecutive cycles starting 1 cycle after first accept. Data in order, `in_ready` never drops.
- Backpressure: raise `write_full` during stream -> exactly one extra accept, `in_ready`=0 next cycle, `write_data` held. Drop `write_full` -> held word then skid word drain in order, no loss.
- Level/almost-full: SIZE=4, thresh=12, `write_pointer`=Gray(13), `read_pointer_grey`=Gray(1) -> `write_level`=12, almost_full=1 next cycle. Wrap case wptr=Gray(2), rptr=Gray(30) -> level=4, almost_full=0. Full: wptr=Gray(16), rptr=Gray(0) -> level=16.
- Reset mid-operation: state TWO holding 0xA5,0x5A, assert reset 1 cycle -> `write_inc`=0 and both words discarded. First post-reset word is the next new input.
- With `FIFO_INGRESS_STATS_EN`: hold `write_full`=1 with data buffered for 10 cycles -> `stall_count`=10. Force 70000 stall cycles -> `stall_count`=0xFFFF. Without macro, always 0.
